// File: rtl/ast_packet_arbiter.sv
// Two-input packet-level round-robin arbiter for Avalon-ST.
// A granted source keeps the output until its EOP word is accepted, so packets
// from the two sources are never interleaved. Words arriving without SOP while
// no source holds the grant are drained and counted as orphans. The output
// side is a single registered stage that stalls under downstream backpressure.
module ast_packet_arbiter #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
) (
  input  logic               clk_i,
  input  logic               srst_i,
  // sink 0
  input  logic [DATA_W-1:0]  ast0_data_i,
  input  logic               ast0_valid_i,
  input  logic               ast0_startofpacket_i,
  input  logic               ast0_endofpacket_i,
  input  logic [EMPTY_W-1:0] ast0_empty_i,
  output logic               ast0_ready_o,
  // sink 1
  input  logic [DATA_W-1:0]  ast1_data_i,
  input  logic               ast1_valid_i,
  input  logic               ast1_startofpacket_i,
  input  logic               ast1_endofpacket_i,
  input  logic [EMPTY_W-1:0] ast1_empty_i,
  output logic               ast1_ready_o,
  // source
  input  logic               ast_ready_i,
  output logic [DATA_W-1:0]  ast_data_o,
  output logic               ast_valid_o,
  output logic               ast_startofpacket_o,
  output logic               ast_endofpacket_o,
  output logic [EMPTY_W-1:0] ast_empty_o,
  output logic               ast_src_o,
  output logic [15:0]        err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;

  // Both sinks gathered into indexable form so the datapath can mux by port.
  logic [DATA_W-1:0]  port_data  [2];
  logic [EMPTY_W-1:0] port_empty [2];
  logic [1:0]         port_valid;
  logic [1:0]         port_sop;
  logic [1:0]         port_eop;

  assign port_data[0]  = ast0_data_i;
  assign port_data[1]  = ast1_data_i;
  assign port_empty[0] = ast0_empty_i;
  assign port_empty[1] = ast1_empty_i;
  assign port_valid    = {ast1_valid_i, ast0_valid_i};
  assign port_sop      = {ast1_startofpacket_i, ast0_startofpacket_i};
  assign port_eop      = {ast1_endofpacket_i, ast0_endofpacket_i};

  // A request is a valid SOP word; a valid non-SOP word seen while idle is an orphan.
  logic [1:0] req;
  logic [1:0] orphan;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req[gi]    = port_valid[gi] && port_sop[gi];
      assign orphan[gi] = port_valid[gi] && !port_sop[gi];
    end
  endgenerate

  // Output register state.
  logic [DATA_W-1:0]  out_data_reg;
  logic               out_valid_reg;
  logic               out_sop_reg;
  logic               out_eop_reg;
  logic [EMPTY_W-1:0] out_empty_reg;
  logic               out_src_reg;
  logic [15:0]        err_cnt_reg;

  // The output stage may take a new word whenever it is empty or being drained.
  logic out_load;
  assign out_load = !out_valid_reg || ast_ready_i;

  logic [1:0] ready_vec;
  logic       accept;
  logic       sel;
  logic [1:0] drop_cnt;
  logic [16:0] err_sum;
  logic [15:0] err_cnt_next;

  // Arbitration, sink handshakes and orphan counting.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    ready_vec       = 2'b00;
    accept          = 1'b0;
    sel             = 1'b0;
    drop_cnt        = 2'd0;
    case (state_reg)
      IDLE: begin
        // Orphans are swallowed immediately; SOP words wait for their grant.
        ready_vec = orphan;
        drop_cnt  = {1'b0, orphan[0]} + {1'b0, orphan[1]};
        if (req == 2'b11) begin
          // Tie goes to the port that did not win last time.
          last_grant_next = ~last_grant_reg;
          state_next      = last_grant_reg ? GNT0 : GNT1;
        end else if (req[0]) begin
          last_grant_next = 1'b0;
          state_next      = GNT0;
        end else if (req[1]) begin
          last_grant_next = 1'b1;
          state_next      = GNT1;
        end
      end
      GNT0: begin
        sel          = 1'b0;
        ready_vec[0] = out_load;
        accept       = port_valid[0] && out_load;
        if (accept && port_eop[0]) begin
          state_next = IDLE;
        end
      end
      GNT1: begin
        sel          = 1'b1;
        ready_vec[1] = out_load;
        accept       = port_valid[1] && out_load;
        if (accept && port_eop[1]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ast0_ready_o = ready_vec[0];
  assign ast1_ready_o = ready_vec[1];

  // Saturating add of up to two dropped words per cycle.
  always_comb begin
    err_sum      = {1'b0, err_cnt_reg} + {15'd0, drop_cnt};
    err_cnt_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Arbiter state and round-robin memory.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Orphan counter.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      err_cnt_reg <= 16'd0;
    end else begin
      err_cnt_reg <= err_cnt_next;
    end
  end

  // Output pipeline stage: capture accepted words, retire drained ones, hold on stall.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_empty_reg <= '0;
      out_src_reg   <= 1'b0;
    end else if (out_load) begin
      if (accept) begin
        out_data_reg  <= port_data[sel];
        out_valid_reg <= 1'b1;
        out_sop_reg   <= port_sop[sel];
        out_eop_reg   <= port_eop[sel];
        out_empty_reg <= port_empty[sel];
        out_src_reg   <= sel;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign ast_data_o          = out_data_reg;
  assign ast_valid_o         = out_valid_reg;
  assign ast_startofpacket_o = out_sop_reg;
  assign ast_endofpacket_o   = out_eop_reg;
  assign ast_empty_o         = out_empty_reg;
  assign ast_src_o           = out_src_reg;
  assign err_cnt_o           = err_cnt_reg;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Bench for ast_packet_arbiter: a transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ast_packet_arbiter;
  localparam int DW = 64;
  localparam int EW = 3;

  logic clk_i = 1'b0;
  logic srst_i;
  always #5 clk_i = ~clk_i;

  logic [DW-1:0] d  [2];
  logic [EW-1:0] em [2];
  logic [1:0]    v, s, e, rdy;
  logic          ast_ready_i;
  logic [DW-1:0] ast_data_o;
  logic          ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_src_o;
  logic [EW-1:0] ast_empty_o;
  logic [15:0]   err_cnt_o;

  ast_packet_arbiter #(.DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .ast0_data_i(d[0]), .ast0_valid_i(v[0]), .ast0_startofpacket_i(s[0]),
    .ast0_endofpacket_i(e[0]), .ast0_empty_i(em[0]), .ast0_ready_o(rdy[0]),
    .ast1_data_i(d[1]), .ast1_valid_i(v[1]), .ast1_startofpacket_i(s[1]),
    .ast1_endofpacket_i(e[1]), .ast1_empty_i(em[1]), .ast1_ready_o(rdy[1]),
    .ast_ready_i(ast_ready_i), .ast_data_o(ast_data_o), .ast_valid_o(ast_valid_o),
    .ast_startofpacket_o(ast_startofpacket_o), .ast_endofpacket_o(ast_endofpacket_o),
    .ast_empty_o(ast_empty_o), .ast_src_o(ast_src_o), .err_cnt_o(err_cnt_o)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model: who owns the output (-1 = nobody), who won last, one output slot.
  int            m_owner, m_last, m_err;
  logic          m_v, m_sop, m_eop, m_src;
  logic [DW-1:0] m_data;
  logic [EW-1:0] m_empty;

  always @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      m_owner <= -1; m_last <= 1; m_err <= 0;
      m_v <= 1'b0; m_sop <= 1'b0; m_eop <= 1'b0; m_src <= 1'b0;
      m_data <= '0; m_empty <= '0;
    end else begin
      bit can_load;
      int p;
      int drops;
      can_load = !m_v || ast_ready_i;
      if (m_owner < 0) begin
        drops = 0;
        for (int q = 0; q < 2; q++) if (v[q] && !s[q]) drops++;
        m_err <= (m_err + drops > 65535) ? 65535 : m_err + drops;
        if (v[0] && s[0] && v[1] && s[1]) p = 1 - m_last;
        else if (v[0] && s[0]) p = 0;
        else if (v[1] && s[1]) p = 1;
        else p = -1;
        if (p >= 0) begin m_owner <= p; m_last <= p; end
        if (can_load) m_v <= 1'b0;
      end else begin
        p = m_owner;
        if (v[p] && can_load) begin
          m_v <= 1'b1; m_data <= d[p]; m_sop <= s[p]; m_eop <= e[p];
          m_empty <= em[p]; m_src <= p[0];
          if (e[p]) m_owner <= -1;
        end else if (can_load) begin
          m_v <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          src, sop, eop;
    logic [EW-1:0] empty;
    int            cyc;
  } beat_t;
  beat_t log_q[$];

  int vectors = 0;
  int miscompares = 0;
  int stall_n = 0;
  int hold0_n = 0;
  bit abort = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Present one word on port p and hold it until the sink accepts it.
  task automatic send_word(input int p, input logic [DW-1:0] dat, input logic sp,
                           input logic ep, input logic [EW-1:0] emp);
    bit acc, done;
    done = 1'b0;
    v[p] = 1'b1; d[p] = dat; s[p] = sp; e[p] = ep; em[p] = emp;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk_i);
      acc = rdy[p];
      if (abort) begin
        v[p] = 1'b0;
        done = 1'b1;
      end else begin
        @(posedge clk_i); #1;
        if (acc) begin v[p] = 1'b0; done = 1'b1; end
      end
    end
    if (!done) begin
      v[p] = 1'b0;
      chk("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic send_pkt(input int p, input int n, input logic [DW-1:0] base,
                          input logic [EW-1:0] emp_last);
    for (int w = 0; w < n; w++) begin
      if (!abort) send_word(p, base + DW'(w), w == 0, w == n - 1, (w == n - 1) ? emp_last : '0);
    end
  endtask

  task automatic do_reset();
    srst_i = 1'b1; v = '0; s = '0; e = '0; ast_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 srst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    int base, c0, st0, hd0;
    logic [7:0] exp_src;
    d[0] = '0; d[1] = '0; em[0] = '0; em[1] = '0;
    srst_i = 1'b1; v = '0; s = '0; e = '0; ast_ready_i = 1'b1;

    // Per-cycle comparison against the model, plus the handshake log.
    fork
      forever begin
        logic [1:0] exp_rdy;
        @(negedge clk_i);
        exp_rdy = 2'b00;
        if (m_owner < 0) exp_rdy = v & ~s;
        else exp_rdy[m_owner] = !m_v || ast_ready_i;
        vectors++;
        if (ast_valid_o !== m_v || rdy !== exp_rdy || err_cnt_o !== m_err[15:0] ||
            (m_v && (ast_data_o !== m_data || ast_src_o !== m_src || ast_startofpacket_o !== m_sop ||
                     ast_endofpacket_o !== m_eop || ast_empty_o !== m_empty))) begin
          miscompares++;
          $display("FAIL cycle_%0d: got v=%b rdy=%b err=%0d data=%h src=%b sop=%b eop=%b emp=%0d, required v=%b rdy=%b err=%0d data=%h src=%b sop=%b eop=%b emp=%0d",
                   cyc, ast_valid_o, rdy, err_cnt_o, ast_data_o, ast_src_o, ast_startofpacket_o,
                   ast_endofpacket_o, ast_empty_o, m_v, exp_rdy, m_err, m_data, m_src, m_sop, m_eop, m_empty);
        end
        if (ast_valid_o && !ast_ready_i) stall_n++;
        if (v[0] && !rdy[0]) hold0_n++;
        if (ast_valid_o && ast_ready_i)
          log_q.push_back('{ast_data_o, ast_src_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, cyc});
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(ast_valid_o), 0);
    chk("rst_data", ast_data_o, 0);
    chk("rst_err", 64'(err_cnt_o), 0);
    chk("rst_ready", 64'(rdy), 0);
    do_reset();

    // 1: single 3-word packet on port 0
    base = log_q.size();
    c0 = cyc;
    send_pkt(0, 3, 64'hA0A0_0000_0000_0000, 3'd4);
    repeat (4) @(posedge clk_i); #1;
    chk("t1_count", 64'(log_q.size() - base), 3);
    if (log_q.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_data", log_q[base+i].data, 64'hA0A0_0000_0000_0000 + 64'(i));
        chk("t1_src", 64'(log_q[base+i].src), 0);
        chk("t1_cycle", 64'(log_q[base+i].cyc), 64'(c0 + 2 + i));
      end
      chk("t1_sop", 64'({log_q[base].sop, log_q[base+2].eop}), 64'b11);
      chk("t1_empty", 64'(log_q[base+2].empty), 4);
    end

    // 2: both ports offer four 2-word packets each
    do_reset();
    base = log_q.size();
    fork
      for (int k = 0; k < 4; k++) send_pkt(0, 2, 64'hB000 + 64'(k * 16), 3'd0);
      for (int k = 0; k < 4; k++) send_pkt(1, 2, 64'hB100 + 64'(k * 16), 3'd0);
    join
    repeat (4) @(posedge clk_i); #1;
    chk("t2_count", 64'(log_q.size() - base), 16);
    exp_src = 8'b1010_1010;  // packet i lives in bit i
    if (log_q.size() >= base + 16) begin
      for (int j = 0; j < 16; j++) begin
        chk("t2_src", 64'(log_q[base+j].src), 64'(exp_src[j/2]));
        chk("t2_data", log_q[base+j].data,
            64'hB000 + 64'((j / 2) % 2) * 64'h100 + 64'((j / 4) * 16) + 64'(j % 2));
        if (j < 15) chk("t2_gap", 64'(log_q[base+j+1].cyc - log_q[base+j].cyc), (j % 2 == 1) ? 2 : 1);
      end
    end

    // 3: backpressure 1,0,0,1 during a 4-word packet
    do_reset();
    base = log_q.size();
    st0 = stall_n;
    hd0 = hold0_n;
    fork
      send_pkt(0, 4, 64'hC0DE_0000_0000_0000, 3'd2);
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk_i);
          seen = ast_valid_o;
        end
        if (!seen) chk("t3_valid_timeout", 64'd0, 64'd1);
        @(posedge clk_i); #1 ast_ready_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1 ast_ready_i = 1'b1;
      end
    join
    repeat (4) @(posedge clk_i); #1;
    chk("t3_count", 64'(log_q.size() - base), 4);
    if (log_q.size() >= base + 4)
      for (int i = 0; i < 4; i++) chk("t3_data", log_q[base+i].data, 64'hC0DE_0000_0000_0000 + 64'(i));
    chk("t3_stalls", 64'(stall_n - st0), 2);
    chk("t3_sink_hold", 64'(hold0_n - hd0), 3);

    // 4: two orphans on port 1, then a real packet
    do_reset();
    base = log_q.size();
    send_word(1, 64'hDEAD_0001, 1'b0, 1'b0, 3'd0);
    send_word(1, 64'hDEAD_0002, 1'b0, 1'b1, 3'd0);
    send_pkt(1, 2, 64'hD100, 3'd5);
    repeat (4) @(posedge clk_i); #1;
    chk("t4_err", 64'(err_cnt_o), 2);
    chk("t4_count", 64'(log_q.size() - base), 2);
    if (log_q.size() >= base + 2)
      for (int i = 0; i < 2; i++) begin
        chk("t4_src", 64'(log_q[base+i].src), 1);
        chk("t4_data", log_q[base+i].data, 64'hD100 + 64'(i));
      end

    // 5: back-to-back single-word packets on port 0
    do_reset();
    base = log_q.size();
    send_word(0, 64'hE001, 1'b1, 1'b1, 3'd7);
    send_word(0, 64'hE002, 1'b1, 1'b1, 3'd7);
    repeat (4) @(posedge clk_i); #1;
    chk("t5_count", 64'(log_q.size() - base), 2);
    if (log_q.size() >= base + 2) begin
      for (int i = 0; i < 2; i++) begin
        chk("t5_data", log_q[base+i].data, 64'hE001 + 64'(i));
        chk("t5_flags", 64'({log_q[base+i].sop, log_q[base+i].eop, log_q[base+i].empty}), 64'b11_111);
      end
      chk("t5_gap", 64'(log_q[base+1].cyc - log_q[base].cyc), 2);
    end

    // 6: asynchronous reset in the middle of a 5-word packet
    do_reset();
    base = log_q.size();
    fork
      send_pkt(0, 5, 64'hF000, 3'd1);
      begin
        for (int t = 0; t < 50 && log_q.size() < base + 1; t++) @(negedge clk_i);
        @(posedge clk_i); #3;
        srst_i = 1'b1;
        abort  = 1'b1;
        #1;
        chk("t6_valid", 64'(ast_valid_o), 0);
        chk("t6_data", ast_data_o, 0);
        chk("t6_flags", 64'({ast_src_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o}), 0);
        chk("t6_err", 64'(err_cnt_o), 0);
      end
    join
    @(posedge clk_i); #1;
    srst_i = 1'b0;
    abort  = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    base = log_q.size();
    send_pkt(0, 3, 64'hF100, 3'd3);
    repeat (4) @(posedge clk_i); #1;
    chk("t6_count", 64'(log_q.size() - base), 3);
    if (log_q.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) chk("t6_after", log_q[base+i].data, 64'hF100 + 64'(i));
      chk("t6_empty", 64'(log_q[base+2].empty), 3);
    end
    chk("t6_err_after", 64'(err_cnt_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
